// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined mux tree.
package mux_pkg;

    // Largest branching ratio the tree is intended to be built with.
    localparam int MUX_MAX_BR = 16;

    // Number of tree levels: smallest L with br**L >= n, never less than one.
    function automatic int levels(input int n, input int br);
        int l;
        int p;
        l = 0;
        p = 1;
        while (p < n) begin
            p = p * br;
            l++;
        end
        if (l < 1) l = 1;
        return l;
    endfunction

    // Low address-bit index of digit k when br is a power of two.
    function automatic int digit_lo(input int k, input int br);
        return k * $clog2(br);
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// One level of the mux tree: BR:1 group muxes plus the stage registers that
// carry data and sideband. No handshake logic lives here; adv gates everything.
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter int W        = 8,
    parameter int TW       = 4,
    parameter int ADRB     = 6,
    parameter int BR       = 8,
    parameter int M        = 64,   // always a multiple of BR (leaves are padded)
    parameter bit CLR_DATA = 1'b0  // clear data/sideband on reset (output stage)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic [W-1:0]    d [M],
    input  logic [ADRB-1:0] adr,
    input  logic [TW-1:0]   tag,
    input  logic            err,
    input  logic            valid,
    output logic [W-1:0]    q [M/BR],
    output logic [ADRB-1:0] adr_q,
    output logic [TW-1:0]   tag_q,
    output logic            err_q,
    output logic            valid_q
);

    int           digit;
    logic [W-1:0] sel [M/BR];

    // The address remainder's lowest base-BR digit selects within each group.
    assign digit = int'(adr) % BR;

    // Group muxes: one BR:1 selection per output word.
    always_comb begin
        for (int g = 0; g < M / BR; g++) begin
            // NOTE: default first so every path assigns sel and no latch is inferred.
            sel[g] = '0;
            for (int j = 0; j < BR; j++) begin
                if (j == digit) sel[g] = d[g*BR + j];
            end
        end
    end

    // Stage registers: valid always advances with adv; payload loads only with a
    // real request so bubbles never overwrite the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every stage sampling pre-edge values.
            valid_q <= 1'b0;
            // NOTE: inner-stage data words are not reset; only valid matters there, and
            // the single-word output stage is cleared so dout reads zero after reset.
            if (CLR_DATA) begin
                for (int g = 0; g < M / BR; g++) q[g] <= '0;
                tag_q <= '0;
                err_q <= 1'b0;
                adr_q <= '0;
            end
        end else if (adv) begin
            valid_q <= valid;
            if (valid) begin
                q     <= sel;
                adr_q <= ADRB'(int'(adr) / BR);
                tag_q <= tag;
                err_q <= err;
            end
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree with valid/ready handshake, sideband tag and
// out-of-range detection. Latency is LVL advancing cycles.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int N    = 64,
    parameter int W    = 8,
    parameter int BR   = 8,
    parameter int TW   = 4,
    parameter int ADRB = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    din [N],
    input  logic [ADRB-1:0] adr_i,
    input  logic [TW-1:0]   tag_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [W-1:0]    dout,
    output logic [TW-1:0]   tag_o,
    output logic            err_o,
    output logic            valid_o,
    input  logic            ready_i
);

    localparam int LVL = levels(N, BR);
    localparam int NP  = BR ** LVL;

    if (BR < 2) begin : g_chk_br
        $error("mux_tree_pipe: BR must be >= 2");
    end
    if (N < 2) begin : g_chk_n
        $error("mux_tree_pipe: N must be >= 2");
    end
    if (ADRB < $clog2(N)) begin : g_chk_adrb
        $error("mux_tree_pipe: ADRB too narrow for N");
    end
    if (((BR & (BR - 1)) != 0) && ((longint'(1) << ADRB) < longint'(N))) begin : g_chk_np2
        $error("mux_tree_pipe: ADRB does not cover N-1 for non power-of-two BR");
    end

    logic [W-1:0] leaves [NP];
    logic         adv;
    logic         adr_err;
    logic [ADRB-1:0] unused_adr;

    // Pad the leaf array up to BR**LVL entries; pads read as zero.
    for (genvar gi = 0; gi < NP; gi++) begin : g_leaf
        if (gi < N) begin : g_real
            assign leaves[gi] = din[gi];
        end else begin : g_pad
            assign leaves[gi] = '0;
        end
    end

    // Global advance: the whole pipe moves unless a held result blocks it.
    assign adv     = ready_i | ~valid_o;
    assign ready_o = adv;
    assign adr_err = {1'b0, adr_i} >= (ADRB + 1)'(N);

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        localparam int M = BR ** (LVL - k);

        logic [W-1:0]    d_in [M];
        logic [ADRB-1:0] adr_in;
        logic [TW-1:0]   tag_in;
        logic            err_in;
        logic            valid_in;
        logic [W-1:0]    q [M/BR];
        logic [ADRB-1:0] adr_q;
        logic [TW-1:0]   tag_q;
        logic            err_q;
        logic            valid_q;

        if (k == 0) begin : g_src
            assign d_in     = leaves;
            assign adr_in   = adr_i;
            assign tag_in   = tag_i;
            assign err_in   = adr_err;
            assign valid_in = valid_i;
        end else begin : g_src
            assign d_in     = g_lvl[k-1].q;
            assign adr_in   = g_lvl[k-1].adr_q;
            assign tag_in   = g_lvl[k-1].tag_q;
            assign err_in   = g_lvl[k-1].err_q;
            assign valid_in = g_lvl[k-1].valid_q;
        end

        mux_tree_stage #(
            .W        (W),
            .TW       (TW),
            .ADRB     (ADRB),
            .BR       (BR),
            .M        (M),
            .CLR_DATA (k == LVL - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv     (adv),
            .d       (d_in),
            .adr     (adr_in),
            .tag     (tag_in),
            .err     (err_in),
            .valid   (valid_in),
            .q       (q),
            .adr_q   (adr_q),
            .tag_q   (tag_q),
            .err_q   (err_q),
            .valid_q (valid_q)
        );
    end

    // Output stage drives the ports; an out-of-range request reads as zero.
    assign unused_adr = g_lvl[LVL-1].adr_q;
    assign valid_o    = g_lvl[LVL-1].valid_q;
    assign err_o      = g_lvl[LVL-1].err_q;
    assign tag_o      = g_lvl[LVL-1].tag_q;
    assign dout       = g_lvl[LVL-1].err_q ? '0 : g_lvl[LVL-1].q[0];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: three configurations (64/8, 10/4, 8/8)
// sharing one clock and reset, driven as a linear sequence of steps.
module tb_mux_tree_pipe;

    logic clk;
    logic rst;

    // Configuration A: N=64, BR=8 (LVL=2)
    logic [7:0] a_din [64];
    logic [5:0] a_adr;
    logic [3:0] a_tag, a_tago;
    logic       a_vi, a_ro, a_erro, a_vo, a_ri;
    logic [7:0] a_dout;

    // Configuration B: N=10, BR=4 (LVL=2, padded to 16)
    logic [7:0] b_din [10];
    logic [3:0] b_adr;
    logic [3:0] b_tag, b_tago;
    logic       b_vi, b_ro, b_erro, b_vo, b_ri;
    logic [7:0] b_dout;

    // Configuration C: N=8, BR=8 (LVL=1)
    logic [7:0] c_din [8];
    logic [2:0] c_adr;
    logic [3:0] c_tag, c_tago;
    logic       c_vi, c_ro, c_erro, c_vo, c_ri;
    logic [7:0] c_dout;

    int n_assert = 0;
    int n_fail   = 0;

    mux_tree_pipe #(.N(64), .W(8), .BR(8), .TW(4)) dut_a (
        .clk(clk), .rst(rst), .din(a_din), .adr_i(a_adr), .tag_i(a_tag),
        .valid_i(a_vi), .ready_o(a_ro), .dout(a_dout), .tag_o(a_tago),
        .err_o(a_erro), .valid_o(a_vo), .ready_i(a_ri)
    );

    mux_tree_pipe #(.N(10), .W(8), .BR(4), .TW(4)) dut_b (
        .clk(clk), .rst(rst), .din(b_din), .adr_i(b_adr), .tag_i(b_tag),
        .valid_i(b_vi), .ready_o(b_ro), .dout(b_dout), .tag_o(b_tago),
        .err_o(b_erro), .valid_o(b_vo), .ready_i(b_ri)
    );

    mux_tree_pipe #(.N(8), .W(8), .BR(8), .TW(4)) c_dut (
        .clk(clk), .rst(rst), .din(c_din), .adr_i(c_adr), .tag_i(c_tag),
        .valid_i(c_vi), .ready_o(c_ro), .dout(c_dout), .tag_o(c_tago),
        .err_o(c_erro), .valid_o(c_vo), .ready_i(c_ri)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_a_dout [4];
        logic [5:0] seq_adr [4];
        int sent, got, hold;
        bit seen;

        exp_a_dout = '{8'h00, 8'h07, 8'h08, 8'h3F};
        seq_adr    = '{6'd0, 6'd7, 6'd8, 6'd63};

        for (int i = 0; i < 64; i++) a_din[i] = 8'(i);
        for (int i = 0; i < 10; i++) b_din[i] = 8'(8'hA0 + i);
        for (int i = 0; i < 8; i++)  c_din[i] = 8'(8'h50 + 3 * i);
        a_adr = '0; a_tag = '0; a_vi = 0; a_ri = 1;
        b_adr = '0; b_tag = '0; b_vi = 0; b_ri = 1;
        c_adr = '0; c_tag = '0; c_vi = 0; c_ri = 1;

        // ---- reset state ----
        rst = 1;
        tick();
        tick();
        check("rst_a_valid_o", a_vo, 0);
        check("rst_a_dout", a_dout, 0);
        check("rst_a_tag_o", a_tago, 0);
        check("rst_a_err_o", a_erro, 0);
        check("rst_b_valid_o", b_vo, 0);
        check("rst_c_dout", c_dout, 0);
        rst = 0;
        #1;
        check("rst_a_ready_o", a_ro, 1);

        // ---- A: adr 0,7,8,63 back to back, tags 1..4 ----
        for (int s = 0; s < 6; s++) begin
            a_vi  = (s < 4);
            a_adr = (s < 4) ? seq_adr[s] : 6'd0;
            a_tag = 4'(s + 1);
            tick();
            if (s >= 1 && s <= 4) begin
                check("a_seq_valid_o", a_vo, 1);
                check("a_seq_dout", a_dout, exp_a_dout[s-1]);
                check("a_seq_tag_o", a_tago, s);
                check("a_seq_err_o", a_erro, 0);
            end else begin
                check("a_seq_idle_valid_o", a_vo, 0);
            end
        end
        a_vi = 0;

        // ---- B: N=10 padded tree, in-range and out-of-range ----
        b_vi = 1; b_adr = 4'd9; b_tag = 4'd5;
        tick();
        check("b_lat_valid_o", b_vo, 0);
        b_adr = 4'd12; b_tag = 4'd6;
        tick();
        b_vi = 0;
        check("b_adr9_valid_o", b_vo, 1);
        check("b_adr9_dout", b_dout, 8'hA9);
        check("b_adr9_err_o", b_erro, 0);
        check("b_adr9_tag_o", b_tago, 5);
        tick();
        check("b_adr12_valid_o", b_vo, 1);
        check("b_adr12_dout", b_dout, 8'h00);
        check("b_adr12_err_o", b_erro, 1);
        check("b_adr12_tag_o", b_tago, 6);
        tick();
        check("b_idle_valid_o", b_vo, 0);

        // ---- A: backpressure, 6 requests adr 10..15, ready_i low 3 clocks ----
        sent = 0; got = 0; hold = 0; seen = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            a_vi  = (sent < 6);
            a_adr = 6'(10 + sent);
            a_tag = 4'(sent + 1);
            if (a_vo && !seen) begin
                seen = 1;
                hold = 3;
            end
            a_ri = (hold == 0);
            #1;
            if (hold > 0) begin
                check("bp_ready_o_low", a_ro, 0);
                check("bp_hold_dout", a_dout, 10 + got);
                check("bp_hold_tag_o", a_tago, got + 1);
            end
            if (a_vo && a_ri) begin
                check("bp_dout", a_dout, 10 + got);
                check("bp_tag_o", a_tago, got + 1);
                got++;
            end
            if (a_vi && a_ro) sent++;
            if (hold > 0) hold--;
            tick();
        end
        a_vi = 0; a_ri = 1;
        check("bp_results_count", got, 6);
        check("bp_no_duplicate", a_vo, 0);

        // ---- A: bubbles 1,0,1,0 ----
        for (int s = 0; s < 6; s++) begin
            a_vi  = (s == 0 || s == 2);
            a_adr = (s == 0) ? 6'd1 : 6'd2;
            a_tag = 4'd0;
            tick();
            check("bub_valid_o", a_vo, (s == 1 || s == 3));
            if (s == 1) check("bub_dout1", a_dout, 8'h01);
            if (s == 3) check("bub_dout2", a_dout, 8'h02);
        end
        a_vi = 0;

        // ---- A: reset mid-stream ----
        a_vi = 1; a_adr = 6'd20; a_tag = 4'd7;
        tick();
        a_adr = 6'd21; a_tag = 4'd8;
        tick();
        check("mid_pre_valid_o", a_vo, 1);
        check("mid_pre_dout", a_dout, 8'd20);
        a_adr = 6'd22; a_tag = 4'd9;
        rst = 1;
        tick();
        check("mid_rst_valid_o", a_vo, 0);
        check("mid_rst_dout", a_dout, 0);
        check("mid_rst_tag_o", a_tago, 0);
        rst = 0;
        a_vi = 0;
        #1;
        check("mid_rst_ready_o", a_ro, 1);
        for (int s = 0; s < 3; s++) begin
            tick();
            check("mid_no_stale", a_vo, 0);
        end
        a_vi = 1; a_adr = 6'd30; a_tag = 4'd10;
        tick();
        a_vi = 0;
        check("mid_new_lat", a_vo, 0);
        tick();
        check("mid_new_valid_o", a_vo, 1);
        check("mid_new_dout", a_dout, 8'd30);
        check("mid_new_tag_o", a_tago, 10);

        // ---- C: single level ----
        c_vi = 1; c_adr = 3'd5; c_tag = 4'd3;
        tick();
        c_vi = 0;
        check("c_valid_o", c_vo, 1);
        check("c_dout", c_dout, 8'h5F);
        check("c_tag_o", c_tago, 3);
        tick();
        check("c_idle_valid_o", c_vo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
